key_conditioner: RTL and testbench

Input conditioning stage that sits directly upstream of the musicbox tone generator. It synchronises and debounces the 16 note switches and the two band buttons. It converts the switch bank into a strictly one-hot note code, with a 4-bit index, and maintains a saturating band register. The tone generator consumes clean registered values and never sees raw asynchronous buttons.

---
 rtl/musicbox_pkg.sv | 29 ++
 rtl/debounce_cell.sv | 46 ++++
 rtl/key_conditioner.sv | 163 ++++++++++++++++
 tb/tb_key_conditioner.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/musicbox_pkg.sv
// Shared constants, the button FSM state type and the note-encode helper for
// the musicbox front end.
package musicbox_pkg;

    localparam int NUM_KEYS = 16;
    localparam int BAND_W   = 4;
    localparam int IDX_W    = 4;
    localparam int CLK_HZ   = 50000000;

    localparam int BAND_MIN_DEF = 1;
    localparam int BAND_MAX_DEF = 8;
    localparam int BAND_RST_DEF = 4;

    typedef enum logic [1:0] {
        BTN_IDLE,
        BTN_PRESS_WAIT,
        BTN_HELD,
        BTN_RELEASE_WAIT
    } btn_state_t;

    // Scanning from the top down leaves the lowest set bit as the winner.
    function automatic logic [IDX_W-1:0] lowest_set_idx(input logic [NUM_KEYS-1:0] v);
        lowest_set_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (v[i]) lowest_set_idx = IDX_W'(i);
        end
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// Two-flop synchroniser followed by a stable-level counter; a vector is
// accepted only after it has stayed unchanged for DB_CYCLES clocks.
module debounce_cell #(
    parameter int               WIDTH     = 1,
    parameter int               DB_CYCLES = 8,
    parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_raw,
    output logic [WIDTH-1:0] o_sync,
    output logic [WIDTH-1:0] o_db
);

    localparam int            CW       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_db;
    logic [CW-1:0]    r_cnt;

    // The counter saturates at CNT_LAST so a long-stable level keeps reloading r_db.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= RST_VAL;
            r_sync2 <= RST_VAL;
            r_db    <= RST_VAL;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync1 != r_sync2) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_db <= r_sync2;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_sync = r_sync2;
    assign o_db   = r_db;

endmodule

// File: rtl/key_conditioner.sv
// Note switch and band button conditioning for the musicbox tone generator.
// Define KEY_CONDITIONER_REPEAT_EN to add auto-repeat on held band buttons.
module key_conditioner
    import musicbox_pkg::*;
#(
    parameter int DB_CYCLES     = 500000,
    parameter int BAND_MIN      = BAND_MIN_DEF,
    parameter int BAND_MAX      = BAND_MAX_DEF,
    parameter int BAND_RST      = BAND_RST_DEF,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] sw_raw,
    input  logic                left_n,
    input  logic                right_n,
    output logic [NUM_KEYS-1:0] note,
    output logic [IDX_W-1:0]    note_idx,
    output logic                note_on,
    output logic                note_change,
    output logic [BAND_W-1:0]   band
);

    logic [NUM_KEYS-1:0] w_sw_db;
    logic [NUM_KEYS-1:0] w_sw_sync_unused;
    logic [1:0]          w_btn_sync;
    logic [1:0]          w_btn_db;
    logic [1:0]          w_step_entry;
    logic [1:0]          w_step;
    logic [NUM_KEYS-1:0] w_note;
    btn_state_t          r_state      [2];
    btn_state_t          w_state_next [2];
    logic [NUM_KEYS-1:0] r_note;
    logic [IDX_W-1:0]    r_note_idx;
    logic                r_note_on;
    logic                r_note_change;
    logic [BAND_W-1:0]   r_band;

    debounce_cell #(.WIDTH(NUM_KEYS), .DB_CYCLES(DB_CYCLES), .RST_VAL({NUM_KEYS{1'b0}})) u_sw_db (
        .clk(clk), .rst_n(rst_n), .i_raw(sw_raw), .o_sync(w_sw_sync_unused), .o_db(w_sw_db)
    );

    // Button slot 0 steps the band up (right), slot 1 steps it down (left).
    debounce_cell #(.WIDTH(1), .DB_CYCLES(DB_CYCLES), .RST_VAL(1'b1)) u_right_db (
        .clk(clk), .rst_n(rst_n), .i_raw(right_n), .o_sync(w_btn_sync[0]), .o_db(w_btn_db[0])
    );

    debounce_cell #(.WIDTH(1), .DB_CYCLES(DB_CYCLES), .RST_VAL(1'b1)) u_left_db (
        .clk(clk), .rst_n(rst_n), .i_raw(left_n), .o_sync(w_btn_sync[1]), .o_db(w_btn_db[1])
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) r_state[b] <= BTN_IDLE;
        end else begin
            for (int b = 0; b < 2; b++) r_state[b] <= w_state_next[b];
        end
    end

    // The synced level aborts a pending transition; the debounced level completes it.
    always_comb begin
        w_state_next = r_state;
        w_step_entry = '0;
        for (int b = 0; b < 2; b++) begin
            case (r_state[b])
                BTN_IDLE: begin
                    if (!w_btn_sync[b]) w_state_next[b] = BTN_PRESS_WAIT;
                end
                BTN_PRESS_WAIT: begin
                    if (w_btn_sync[b]) begin
                        w_state_next[b] = BTN_IDLE;
                    end else if (!w_btn_db[b]) begin
                        w_state_next[b] = BTN_HELD;
                        w_step_entry[b] = 1'b1;
                    end
                end
                BTN_HELD: begin
                    if (w_btn_sync[b]) w_state_next[b] = BTN_RELEASE_WAIT;
                end
                BTN_RELEASE_WAIT: begin
                    if (!w_btn_sync[b] && !w_btn_db[b]) begin
                        w_state_next[b] = BTN_HELD;
                    end else if (w_btn_db[b]) begin
                        w_state_next[b] = BTN_IDLE;
                    end
                end
                default: w_state_next[b] = BTN_IDLE;
            endcase
        end
    end

`ifdef KEY_CONDITIONER_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + 1);

    logic [RW-1:0] r_rep [2];
    logic [1:0]    w_rep_step;

    always_comb begin
        w_rep_step = '0;
        for (int b = 0; b < 2; b++) begin
            w_rep_step[b] = (r_state[b] == BTN_HELD) && (r_rep[b] == RW'(REPEAT_DELAY - 1));
        end
    end

    // After each repeat the counter rewinds so the next one lands REPEAT_PERIOD later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) r_rep[b] <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (r_state[b] != BTN_HELD || w_state_next[b] != BTN_HELD) begin
                    r_rep[b] <= '0;
                end else if (w_rep_step[b]) begin
                    r_rep[b] <= RW'(REPEAT_DELAY - REPEAT_PERIOD);
                end else begin
                    r_rep[b] <= r_rep[b] + RW'(1);
                end
            end
        end
    end

    assign w_step = w_step_entry | w_rep_step;
`else
    localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;

    assign w_step = w_step_entry;
`endif

    // Simultaneous up and down steps cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_band <= BAND_W'(BAND_RST);
        end else if (w_step[0] && !w_step[1] && r_band < BAND_W'(BAND_MAX)) begin
            r_band <= r_band + BAND_W'(1);
        end else if (w_step[1] && !w_step[0] && r_band > BAND_W'(BAND_MIN)) begin
            r_band <= r_band - BAND_W'(1);
        end
    end

    assign w_note = w_sw_db & (~w_sw_db + NUM_KEYS'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_note        <= '0;
            r_note_idx    <= '0;
            r_note_on     <= 1'b0;
            r_note_change <= 1'b0;
        end else begin
            r_note        <= w_note;
            r_note_idx    <= lowest_set_idx(w_sw_db);
            r_note_on     <= |w_sw_db;
            r_note_change <= (w_note != r_note);
        end
    end

    assign note        = r_note;
    assign note_idx    = r_note_idx;
    assign note_on     = r_note_on;
    assign note_change = r_note_change;
    assign band        = r_band;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed self-checking bench for key_conditioner with short debounce and
// repeat timings; expected band values follow KEY_CONDITIONER_REPEAT_EN.
module tb_key_conditioner;

    logic        clk;
    logic        rst_n;
    logic [15:0] sw_raw;
    logic        left_n;
    logic        right_n;
    logic [15:0] note;
    logic [3:0]  note_idx;
    logic        note_on;
    logic        note_change;
    logic [3:0]  band;

    int checks     = 0;
    int failures   = 0;
    int pulseCount = 0;

    typedef struct {
        logic [15:0] sw;
        logic [15:0] expNote;
        logic [3:0]  expIdx;
        logic        expOn;
        int          expPulses;
    } vec_t;

    vec_t vecs [8];

    key_conditioner #(.DB_CYCLES(8), .REPEAT_DELAY(40), .REPEAT_PERIOD(16)) dut (
        .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw), .left_n(left_n), .right_n(right_n),
        .note(note), .note_idx(note_idx), .note_on(note_on), .note_change(note_change),
        .band(band)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (note_change) pulseCount++;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit useRight, input bit useLeft, input int holdCycles);
        if (useRight) right_n = 1'b0;
        if (useLeft)  left_n  = 1'b0;
        waitCycles(holdCycles);
        right_n = 1'b1;
        left_n  = 1'b1;
        waitCycles(20);
    endtask

    initial begin
        int  p0;
        bit  sawNote;
        int  expBand;

        vecs[0] = '{16'h0A00, 16'h0200, 4'd9,  1'b1, 1};
        vecs[1] = '{16'h0A01, 16'h0001, 4'd0,  1'b1, 1};
        vecs[2] = '{16'h0003, 16'h0001, 4'd0,  1'b1, 0};
        vecs[3] = '{16'h0001, 16'h0001, 4'd0,  1'b1, 0};
        vecs[4] = '{16'h8000, 16'h8000, 4'd15, 1'b1, 1};
        vecs[5] = '{16'hFFFF, 16'h0001, 4'd0,  1'b1, 1};
        vecs[6] = '{16'h4400, 16'h0400, 4'd10, 1'b1, 1};
        vecs[7] = '{16'h0000, 16'h0000, 4'd0,  1'b0, 1};

        sw_raw  = '0;
        left_n  = 1'b1;
        right_n = 1'b1;
        rst_n   = 1'b0;
        waitCycles(1);

        for (int i = 0; i < 6; i++) begin
            sw_raw  = 16'($urandom);
            left_n  = 1'($urandom);
            right_n = 1'($urandom);
            waitCycles(1);
        end
        checkOutput("rst_note", 32'(note), 32'h0);
        checkOutput("rst_idx", 32'(note_idx), 32'h0);
        checkOutput("rst_on", 32'(note_on), 32'h0);
        checkOutput("rst_change", 32'(note_change), 32'h0);
        checkOutput("rst_band", 32'(band), 32'd4);

        sw_raw  = '0;
        left_n  = 1'b1;
        right_n = 1'b1;
        waitCycles(2);
        rst_n = 1'b1;
        p0 = pulseCount;
        waitCycles(20);
        checkOutput("idle_band", 32'(band), 32'd4);
        checkOutput("idle_note", 32'(note), 32'h0);
        checkOutput("idle_pulses", 32'(pulseCount - p0), 32'd0);

        // Latency from the raw edge is 11 clocks with DB_CYCLES = 8.
        sw_raw = 16'h0010;
        p0 = pulseCount;
        waitCycles(10);
        checkOutput("lat_early_note", 32'(note), 32'h0);
        waitCycles(1);
        checkOutput("lat_note", 32'(note), 32'h0010);
        checkOutput("lat_idx", 32'(note_idx), 32'd4);
        checkOutput("lat_on", 32'(note_on), 32'h1);
        checkOutput("lat_change", 32'(note_change), 32'h1);
        waitCycles(1);
        checkOutput("lat_change_end", 32'(note_change), 32'h0);
        waitCycles(10);
        checkOutput("lat_pulses", 32'(pulseCount - p0), 32'd1);

        sw_raw = '0;
        p0 = pulseCount;
        waitCycles(16);
        checkOutput("off_note", 32'(note), 32'h0);
        checkOutput("off_on", 32'(note_on), 32'h0);
        checkOutput("off_idx", 32'(note_idx), 32'h0);
        checkOutput("off_pulses", 32'(pulseCount - p0), 32'd1);

        p0 = pulseCount;
        sawNote = 1'b0;
        for (int c = 0; c < 60; c++) begin
            sw_raw = ((c / 3) % 2 == 1) ? 16'h0040 : 16'h0000;
            waitCycles(1);
            if (note != 16'h0) sawNote = 1'b1;
        end
        sw_raw = '0;
        waitCycles(16);
        checkOutput("bounce_sw_note_seen", 32'(sawNote), 32'h0);
        checkOutput("bounce_sw_pulses", 32'(pulseCount - p0), 32'd0);

        for (int v = 0; v < 8; v++) begin
            sw_raw = vecs[v].sw;
            p0 = pulseCount;
            waitCycles(16);
            checkOutput($sformatf("vec%0d_note", v), 32'(note), 32'(vecs[v].expNote));
            checkOutput($sformatf("vec%0d_idx", v), 32'(note_idx), 32'(vecs[v].expIdx));
            checkOutput($sformatf("vec%0d_on", v), 32'(note_on), 32'(vecs[v].expOn));
            checkOutput($sformatf("vec%0d_pulses", v), 32'(pulseCount - p0), 32'(vecs[v].expPulses));
        end

        expBand = 4;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 1'b0, 20);
            if (expBand < 8) expBand++;
            checkOutput($sformatf("up%0d_band", k), 32'(band), 32'(expBand));
        end
        for (int k = 0; k < 9; k++) begin
            applyStimulus(1'b0, 1'b1, 20);
            if (expBand > 1) expBand--;
            checkOutput($sformatf("down%0d_band", k), 32'(band), 32'(expBand));
        end

        // Held for 70 cycles: repeats land 40 and 56 cycles after the entry step.
        applyStimulus(1'b1, 1'b0, 70);
`ifdef KEY_CONDITIONER_REPEAT_EN
        expBand = 4;
`else
        expBand = 2;
`endif
        checkOutput("hold_band", 32'(band), 32'(expBand));

        for (int g = 0; g < 3; g++) begin
            right_n = 1'b0;
            waitCycles(1);
            right_n = 1'b1;
            waitCycles(1);
        end
        right_n = 1'b0;
        waitCycles(20);
        for (int g = 0; g < 3; g++) begin
            right_n = 1'b1;
            waitCycles(1);
            right_n = 1'b0;
            waitCycles(1);
        end
        right_n = 1'b1;
        waitCycles(20);
        expBand++;
        checkOutput("bounced_press_band", 32'(band), 32'(expBand));

        applyStimulus(1'b1, 1'b1, 20);
        checkOutput("both_band", 32'(band), 32'(expBand));

        right_n = 1'b0;
        waitCycles(5);
        rst_n = 1'b0;
        waitCycles(1);
        right_n = 1'b1;
        waitCycles(2);
        checkOutput("midpress_rst_band", 32'(band), 32'd4);
        rst_n = 1'b1;
        p0 = pulseCount;
        waitCycles(30);
        checkOutput("after_rst_band", 32'(band), 32'd4);
        checkOutput("after_rst_pulses", 32'(pulseCount - p0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
